// File: rtl/ecdsa_mul_pkg.sv
// ---------------------------------------------------------------------------
// ecdsa_mul_pkg
// Shared definitions for the wide-operand multiplier datapath.
//   - DEF_WORD_W / DEF_OP_W / DEF_LANES : default limb width, wide operand
//     width and number of parallel limb multipliers
//   - IDLE_ENC / MUL_ENC / FLUSH_ENC / FIN_ENC : state encodings, plus the
//     mul_state_e enum built from them
//   - calc_passes / calc_res_w : derived pass count and result width
// No ports (package).
// ---------------------------------------------------------------------------
package ecdsa_mul_pkg;

    localparam int DEF_WORD_W = 16;
    localparam int DEF_OP_W   = 256;
    localparam int DEF_LANES  = 4;

    localparam logic [1:0] IDLE_ENC  = 2'd0;
    localparam logic [1:0] MUL_ENC   = 2'd1;
    localparam logic [1:0] FLUSH_ENC = 2'd2;
    localparam logic [1:0] FIN_ENC   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = IDLE_ENC,
        MUL   = MUL_ENC,
        FLUSH = FLUSH_ENC,
        FIN   = FIN_ENC
    } mul_state_e;

    // Number of LANES-wide slices the wide operand is split into.
    function automatic int calc_passes(input int op_w, input int word_w, input int lanes);
        return op_w / (word_w * lanes);
    endfunction

    // Exact product width of a word_w-bit scalar times an op_w-bit operand.
    function automatic int calc_res_w(input int op_w, input int word_w);
        return op_w + word_w;
    endfunction

endpackage

// File: rtl/mul_16x16.sv
// ---------------------------------------------------------------------------
// mul_16x16
// Single limb multiplier: unsigned WORD_W x WORD_W -> 2*WORD_W, purely
// combinational. One instance per lane in the wide multiplier.
// Ports:
//   a  in  WORD_W     limb operand
//   b  in  WORD_W     limb operand
//   p  out 2*WORD_W   exact product a*b
// ---------------------------------------------------------------------------
module mul_16x16
    import ecdsa_mul_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic [WORD_W-1:0]   a,
    input  logic [WORD_W-1:0]   b,
    output logic [2*WORD_W-1:0] p
);

    assign p = (2*WORD_W)'(a) * (2*WORD_W)'(b);

endmodule

// File: rtl/mul_lane_slice.sv
// ---------------------------------------------------------------------------
// mul_lane_slice
// Stage-2 combine for one pass: sums the LANES registered limb products at
// their limb offsets, the carry word from the previous pass and, when
// MUL_ACC_EN is defined, the matching chunk of the accumulate operand.
// Config macro: MUL_ACC_EN (adds the acc_chunk input).
// Ports:
//   prod       in   LANES x 2*WORD_W     products a*b_chunk[j]
//   carry_in   in   WORD_W               carry word from the previous pass
//   acc_chunk  in   LANES*WORD_W         addend chunk (MUL_ACC_EN only)
//   sum        out  (LANES+1)*WORD_W     pass sum; top word is the next carry
// ---------------------------------------------------------------------------
module mul_lane_slice
    import ecdsa_mul_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int LANES  = DEF_LANES
) (
    input  logic [LANES-1:0][2*WORD_W-1:0] prod,
    input  logic [WORD_W-1:0]              carry_in,
`ifdef MUL_ACC_EN
    input  logic [LANES*WORD_W-1:0]        acc_chunk,
`endif
    output logic [(LANES+1)*WORD_W-1:0]    sum
);

    localparam int SW = (LANES + 1) * WORD_W;

    logic [SW-1:0] total;

    // The bound (2^CW-1)*(2^W-1) + (2^W-1) + (2^CW-1) is below 2^SW, so the
    // top word of total always fits in one carry word.
    always_comb begin
        total = SW'(carry_in);
`ifdef MUL_ACC_EN
        total = total + SW'(acc_chunk);
`else
        // Without the accumulate term only the carry and products contribute.
`endif
        for (int j = 0; j < LANES; j++) begin
            total = total + (SW'(prod[j]) << (j * WORD_W));
        end
    end

    assign sum = total;

endmodule

// File: rtl/mul_word_by_wide_mac.sv
// ---------------------------------------------------------------------------
// mul_word_by_wide_mac
// Iterative multiplier: WORD_W-bit scalar times OP_W-bit operand giving the
// exact (OP_W+WORD_W)-bit product, LANES limbs per pass, with a
// start/busy/done handshake. Optional accumulate term under MUL_ACC_EN.
// Config macro: MUL_ACC_EN (adds acc_in, result = a*b + acc_in).
// Ports:
//   clk     in   1        rising-edge clock
//   reset   in   1        asynchronous active-high reset (aborts an operation)
//   start   in   1        request, sampled only in IDLE
//   a       in   WORD_W   scalar, captured on accepted start
//   b       in   OP_W     wide operand, captured on accepted start
//   acc_in  in   OP_W     addend, captured on accepted start (MUL_ACC_EN only)
//   busy    out  1        high from the cycle after acceptance until done
//   done    out  1        one-cycle pulse when out is valid
//   out     out  RES_W    result, held until the next accepted start
// ---------------------------------------------------------------------------
module mul_word_by_wide_mac
    import ecdsa_mul_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int OP_W   = DEF_OP_W,
    parameter int LANES  = DEF_LANES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WORD_W-1:0]      a,
    input  logic [OP_W-1:0]        b,
`ifdef MUL_ACC_EN
    input  logic [OP_W-1:0]        acc_in,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [OP_W+WORD_W-1:0] out
);

    localparam int PASSES = calc_passes(OP_W, WORD_W, LANES);
    localparam int RES_W  = calc_res_w(OP_W, WORD_W);
    localparam int CW     = WORD_W * LANES;
    localparam int SW     = CW + WORD_W;
    localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;

    mul_state_e                      state_q, state_d;
    logic [WORD_W-1:0]               a_q, a_d;
    logic [OP_W-1:0]                 b_q, b_d;
`ifdef MUL_ACC_EN
    logic [OP_W-1:0]                 acc_q, acc_d;
`endif
    logic [LANES-1:0][2*WORD_W-1:0]  prod_q, prod_d;
    logic                            prod_vld_q, prod_vld_d;
    logic [WORD_W-1:0]               carry_q, carry_d;
    logic [PASS_W-1:0]               pass_q, pass_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic [RES_W-1:0]                out_q, out_d;

    logic [LANES-1:0][2*WORD_W-1:0]  lane_prod;
    logic [SW-1:0]                   sum;
    logic [CW+OP_W-1:0]              out_shift;

    // Stage 1: b_q is shifted down every MUL cycle, so the lanes always
    // multiply the lowest LANES limbs of what is left of the operand.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        mul_16x16 #(
            .WORD_W (WORD_W)
        ) u_mul (
            .a (a_q),
            .b (b_q[j*WORD_W +: WORD_W]),
            .p (lane_prod[j])
        );
    end

    mul_lane_slice #(
        .WORD_W (WORD_W),
        .LANES  (LANES)
    ) u_slice (
        .prod      (prod_q),
        .carry_in  (carry_q),
`ifdef MUL_ACC_EN
        .acc_chunk (acc_q[CW-1:0]),
`endif
        .sum       (sum)
    );

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
`ifdef MUL_ACC_EN
        acc_d      = acc_q;
`endif
        prod_d     = prod_q;
        prod_vld_d = 1'b0;
        carry_d    = carry_q;
        pass_d     = pass_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        out_d      = out_q;
        out_shift  = {sum[CW-1:0], out_q[OP_W-1:0]};

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
`ifdef MUL_ACC_EN
                    acc_d   = acc_in;
`endif
                    pass_d  = '0;
                    carry_d = '0;
                    busy_d  = 1'b1;
                    state_d = MUL;
                end
            end
            MUL: begin
                prod_d     = lane_prod;
                prod_vld_d = 1'b1;
                b_d        = b_q >> CW;
                pass_d     = PASS_W'(pass_q + 1'b1);
                if (pass_q == PASS_W'(PASSES - 1)) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Stage 2 runs one cycle behind stage 1. Each pass shifts its low CW
        // bits in from the top of the OP_W field; the carry word rides in
        // the top WORD_W of out so it is already in place after the last pass.
        if (prod_vld_q) begin
            carry_d = sum[SW-1 -: WORD_W];
            out_d   = {sum[SW-1 -: WORD_W], out_shift[CW +: OP_W]};
`ifdef MUL_ACC_EN
            acc_d   = acc_q >> CW;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
`ifdef MUL_ACC_EN
            acc_q      <= '0;
`endif
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            carry_q    <= '0;
            pass_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
`ifdef MUL_ACC_EN
            acc_q      <= acc_d;
`endif
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            carry_q    <= carry_d;
            pass_q     <= pass_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            out_q      <= out_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: tb/tb_mul_word_by_wide_mac.sv
// ---------------------------------------------------------------------------
// tb_mul_word_by_wide_mac
// Self-checking bench for mul_word_by_wide_mac at default parameters.
// A timing model tracks when the DUT should accept a start, pushes the
// reference result a*b(+acc) into a scoreboard queue, and pops it in the
// cycle done is due. Honours MUL_ACC_EN for the acc_in port.
// ---------------------------------------------------------------------------
module tb_mul_word_by_wide_mac;

    localparam int WORD_W = 16;
    localparam int OP_W   = 256;
    localparam int LANES  = 4;
    localparam int PASSES = OP_W / (WORD_W * LANES);
    localparam int RES_W  = OP_W + WORD_W;
    localparam int LAT    = PASSES + 2;
`ifdef MUL_ACC_EN
    localparam bit ACC_ON = 1'b1;
`else
    localparam bit ACC_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [WORD_W-1:0] a;
    logic [OP_W-1:0]   b;
    logic [OP_W-1:0]   acc_drv;
    logic              busy;
    logic              done;
    logic [RES_W-1:0]  out;

    int               vectors     = 0;
    int               miscompares = 0;
    int               model_cnt   = 0;
    logic [RES_W-1:0] last_exp    = '0;
    logic [RES_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    mul_word_by_wide_mac #(
        .WORD_W (WORD_W),
        .OP_W   (OP_W),
        .LANES  (LANES)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
`ifdef MUL_ACC_EN
        .acc_in (acc_drv),
`endif
        .busy   (busy),
        .done   (done),
        .out    (out)
    );

    task automatic check_output(input string tag, input logic [RES_W-1:0] got,
                                input logic [RES_W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [RES_W-1:0] ref_result(input logic [WORD_W-1:0] av,
                                                    input logic [OP_W-1:0] bv,
                                                    input logic [OP_W-1:0] accv);
        return RES_W'(av) * RES_W'(bv) + RES_W'(accv);
    endfunction

    function automatic logic [OP_W-1:0] rand_wide();
        logic [OP_W-1:0] r;
        r = '0;
        for (int i = 0; i < OP_W / 32; i++) begin
            r = {r[OP_W-33:0], 32'($urandom())};
        end
        return r;
    endfunction

    // Timing model: an op accepted at edge t shows done in the cycle after
    // edge t+LAT-1 and the next start can be accepted LAT+1 edges later.
    always @(posedge clk) begin
        if (reset) begin
            model_cnt = 0;
            exp_q.delete();
            last_exp = '0;
        end else if (model_cnt == 0 && start) begin
            exp_q.push_back(ref_result(a, b, acc_drv));
            model_cnt = LAT;
        end else if (model_cnt > 0) begin
            model_cnt--;
        end
    end

    // Monitor on the falling edge: handshake every cycle, result on done,
    // and result held stable while idle.
    always @(negedge clk) begin
        if (!reset) begin
            check_output("busy", RES_W'(busy), RES_W'(model_cnt >= 2));
            check_output("done", RES_W'(done), RES_W'(model_cnt == 1));
            if (model_cnt == 1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL scoreboard: got empty queue, expected one entry");
                end else begin
                    last_exp = exp_q.pop_front();
                    check_output("out_at_done", out, last_exp);
                end
            end else if (model_cnt == 0) begin
                check_output("out_hold", out, last_exp);
            end
        end
    end

    // Single-cycle start pulse, then wait until the op has fully drained.
    task automatic apply_stimulus(input logic [WORD_W-1:0] av, input logic [OP_W-1:0] bv,
                                  input logic [OP_W-1:0] accv);
        @(posedge clk);
        #2;
        start   = 1'b1;
        a       = av;
        b       = bv;
        acc_drv = ACC_ON ? accv : '0;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (LAT) @(posedge clk);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        acc_drv = '0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (3) @(posedge clk);

        // Directed corner cases
        apply_stimulus(16'hFFFF, '1, '0);
        apply_stimulus(16'h0003, (256'h1 << 64) | 256'h1, '0);
        apply_stimulus(16'h0001, '1, 256'h1);
        apply_stimulus(16'h0000, rand_wide(), rand_wide());
        apply_stimulus(16'hBEEF, '0, rand_wide());
        apply_stimulus(16'hFFFF, '1, '1);

        // start held for 20 cycles with operands changing every cycle
        @(posedge clk);
        #2;
        for (int i = 0; i < 20; i++) begin
            start   = 1'b1;
            a       = WORD_W'($urandom());
            b       = rand_wide();
            acc_drv = ACC_ON ? rand_wide() : '0;
            @(posedge clk);
            #2;
        end
        start = 1'b0;
        repeat (LAT + 2) @(posedge clk);

        // Reset pulsed in cycle 3 of an operation
        #2;
        start   = 1'b1;
        a       = 16'h1234;
        b       = rand_wide();
        acc_drv = ACC_ON ? rand_wide() : '0;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_output("rst_busy", RES_W'(busy), '0);
        check_output("rst_done", RES_W'(done), '0);
        check_output("rst_out", out, '0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        apply_stimulus(16'hA5A5, rand_wide(), rand_wide());

        // Random vectors
        for (int i = 0; i < 40; i++) begin
            apply_stimulus(WORD_W'($urandom()), rand_wide(), rand_wide());
        end

        repeat (3) @(posedge clk);
        check_output("queue_empty", RES_W'(exp_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
